// File: rtl/mem_access_seq.sv
// ---------------------------------------------------------------------------
// mem_access_seq
//
// Purpose:
//   Load/store sequencer that sits directly in front of the 8x11-bit data RAM
//   of the 4-bit CPU. It turns one load/store request into the RAM port
//   activity that the request needs. There are two addressing modes:
//     - direct   : the access uses the request address.
//     - indirect : first read a pointer cell through read port 1, then do the
//                  access at the address held in that cell.
//   The sequencer drives only the RAM write port and read port 1. Read port 2
//   stays with the datapath.
//
// Parameters:
//   DATA_W   RAM word width.
//   ADDR_W   RAM address width.
//   PTR_LSB  Lowest bit of the pointer field inside a RAM word.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   asynchronous, active-low reset
//   start           in   request strobe, sampled only while idle
//   is_store        in   1 = store, 0 = load
//   indirect        in   1 = indirect through a pointer cell, 0 = direct
//   addr            in   direct address, or pointer-cell address
//   wdata           in   store data
//   Read_Data_1     in   RAM read port 1 data (combinational in address)
//   Read_Address_1  out  RAM read port 1 address
//   Write_Address   out  RAM write address
//   Write_Data      out  RAM write data
//   Write_Enable    out  RAM write strobe
//   rdata           out  result of the last load
//   busy            out  a request is in progress
//   done            out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module mem_access_seq #(
  parameter int DATA_W  = 11,
  parameter int ADDR_W  = 3,
  parameter int PTR_LSB = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic              indirect,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] Read_Data_1,
  output logic [ADDR_W-1:0] Read_Address_1,
  output logic [ADDR_W-1:0] Write_Address,
  output logic [DATA_W-1:0] Write_Data,
  output logic              Write_Enable,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PTR    = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Request fields latched at acceptance, so later input changes cannot
  // disturb a request that is already running.
  logic              isStore_q,  isStore_d;
  logic              indirect_q, indirect_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [ADDR_W-1:0] ptr_q,      ptr_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;

  logic [ADDR_W-1:0] effAddr;

  // The address the ACCESS cycle works on: the pointer fetched from RAM in
  // indirect mode, otherwise the address latched with the request.
  assign effAddr = indirect_q ? ptr_q : addr_q;

  // State register. Reset drops the request at once, so a store that was
  // interrupted never reaches its write cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start counts only in IDLE, so a strobe that arrives
  // while a request is running is dropped, not queued. DONE always goes back
  // to IDLE, which is the cycle in which a held start is accepted again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = indirect ? PTR : ACCESS;
        end
      end
      PTR:     state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the request registers. The pointer is captured at the
  // end of PTR. Only the pointer field of that word is kept; the other bits
  // of the pointer cell are ignored. A load result is captured at the end
  // of ACCESS. Stores leave rdata unchanged.
  always_comb begin
    isStore_d  = isStore_q;
    indirect_d = indirect_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ptr_d      = ptr_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          isStore_d  = is_store;
          indirect_d = indirect;
          addr_d     = addr;
          wdata_d    = wdata;
        end
      end
      PTR: begin
        ptr_d = Read_Data_1[PTR_LSB +: ADDR_W];
      end
      ACCESS: begin
        if (!isStore_q) begin
          rdata_d = Read_Data_1;
        end
      end
      default: begin
      end
    endcase
  end

  // Request and result registers. All of them clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      isStore_q  <= 1'b0;
      indirect_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ptr_q      <= '0;
      rdata_q    <= '0;
    end else begin
      isStore_q  <= isStore_d;
      indirect_q <= indirect_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ptr_q      <= ptr_d;
      rdata_q    <= rdata_d;
    end
  end

  // Output decode. Every output comes from registered state and latched
  // fields only. The write port stays at zero except during the ACCESS
  // cycle of a store. That cycle lasts exactly one clock, so a store gives
  // exactly one write strobe.
  always_comb begin
    Read_Address_1 = '0;
    Write_Address  = '0;
    Write_Data     = '0;
    Write_Enable   = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state_q)
      IDLE: begin
      end
      PTR: begin
        busy           = 1'b1;
        Read_Address_1 = addr_q;
      end
      ACCESS: begin
        busy           = 1'b1;
        Read_Address_1 = effAddr;
        if (isStore_q) begin
          Write_Enable  = 1'b1;
          Write_Address = effAddr;
          Write_Data    = wdata_q;
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign rdata = rdata_q;

endmodule
